light_phase_sequencer: RTL

Downstream stage of the traffic-mode selector: consumes the 8-bit lane-select word produced by the mode mux and drives the physical per-lane red/yellow/green lamps. Every change of the selected lane set goes through a timed yellow interval and an all-red clearance interval before the new lanes turn green. Clocked by the 1-second system clock, so all timing parameters are in seconds (cycles).

---
 rtl/light_phase_sequencer_pkg.sv | 27 ++
 rtl/light_phase_sequencer_phase_timer.sv | 38 +++
 rtl/light_phase_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/light_phase_sequencer_pkg.sv
// Shared types and default timing for the lane lamp sequencer.
// Timing constants are in seconds, i.e. cycles of the 1 s system clock.
package light_phase_sequencer_pkg;

   typedef enum logic [1:0] {
      CLEAR  = 2'd0,
      GREEN  = 2'd1,
      YELLOW = 2'd2
   } phase_e;

   localparam int LANES_DEF        = 8;
   localparam int YELLOW_TIME_DEF  = 3;
   localparam int ALL_RED_TIME_DEF = 2;
   localparam int MIN_GREEN_DEF    = 5;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Width that holds the longest interval minus one, with headroom for the full value.
   function automatic int cnt_width(input int yellow_t, input int all_red_t, input int min_green);
      return $clog2(max3(yellow_t, all_red_t, min_green) + 1);
   endfunction

endpackage

// File: rtl/light_phase_sequencer_phase_timer.sv
// Loadable down counter that saturates at zero; times every phase interval.
module light_phase_sequencer_phase_timer #(
   parameter int W         = 3,
   parameter int RESET_VAL = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] cnt,
   output logic         zero
);

   logic [W-1:0] cnt_d;
   logic [W-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= W'(RESET_VAL);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);

endmodule

// File: rtl/light_phase_sequencer.sv
// Drives per-lane red/yellow/green lamps; every lane-set change passes through
// a timed yellow interval and an all-red clearance before the new set turns green.
module light_phase_sequencer
   import light_phase_sequencer_pkg::*;
#(
   parameter int LANES        = LANES_DEF,
   parameter int YELLOW_TIME  = YELLOW_TIME_DEF,
   parameter int ALL_RED_TIME = ALL_RED_TIME_DEF,
   parameter int MIN_GREEN    = MIN_GREEN_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [LANES-1:0] req_green,
   input  logic             emg_override,
   output logic [LANES-1:0] green,
   output logic [LANES-1:0] yellow,
   output logic [LANES-1:0] red,
   output logic             grant_pulse,
   output logic             busy
);

   localparam int CNT_W = cnt_width(YELLOW_TIME, ALL_RED_TIME, MIN_GREEN);

   localparam logic [CNT_W-1:0] LOAD_GREEN  = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] LOAD_YELLOW = CNT_W'(YELLOW_TIME - 1);
   localparam logic [CNT_W-1:0] LOAD_CLEAR  = CNT_W'(ALL_RED_TIME - 1);

   phase_e           state_d, state_q;
   logic [LANES-1:0] active_d, active_q;
   logic [LANES-1:0] green_d, green_q;
   logic [LANES-1:0] yellow_d, yellow_q;
   logic [LANES-1:0] red_d, red_q;
   logic             grant_pulse_d, grant_pulse_q;
   logic             busy_d, busy_q;

   logic             timer_load;
   logic [CNT_W-1:0] timer_load_val;
   logic [CNT_W-1:0] timer_cnt;
   logic             timer_zero;

   light_phase_sequencer_phase_timer #(
      .W         (CNT_W),
      .RESET_VAL (ALL_RED_TIME - 1)
   ) u_phase_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (timer_load_val),
      .cnt      (timer_cnt),
      .zero     (timer_zero)
   );

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d        = state_q;
      active_d       = active_q;
      grant_pulse_d  = 1'b0;
      timer_load     = 1'b0;
      timer_load_val = '0;

      unique case (state_q)
         CLEAR: begin
            if (timer_zero && (req_green != '0)) begin
               state_d        = GREEN;
               active_d       = req_green;
               grant_pulse_d  = 1'b1;
               timer_load     = 1'b1;
               timer_load_val = LOAD_GREEN;
            end
         end
         GREEN: begin
            // Emergency mode only waives the remaining minimum-green hold.
            if ((req_green != active_q) && (timer_zero || emg_override)) begin
               state_d        = YELLOW;
               timer_load     = 1'b1;
               timer_load_val = LOAD_YELLOW;
            end
         end
         YELLOW: begin
            if (timer_zero) begin
               state_d        = CLEAR;
               active_d       = '0;
               timer_load     = 1'b1;
               timer_load_val = LOAD_CLEAR;
            end
         end
         default: begin
            state_d        = CLEAR;
            active_d       = '0;
            timer_load     = 1'b1;
            timer_load_val = LOAD_CLEAR;
         end
      endcase
   end

   // Lamps are decoded from the next state so they register together with it.
   always_comb begin
      green_d  = '0;
      yellow_d = '0;
      red_d    = '1;
      busy_d   = (state_d != GREEN);
      unique case (state_d)
         GREEN: begin
            green_d = active_d;
            red_d   = ~active_d;
         end
         YELLOW: begin
            yellow_d = active_d;
            red_d    = ~active_d;
         end
         default: begin
            red_d = '1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= CLEAR;
         active_q      <= '0;
         green_q       <= '0;
         yellow_q      <= '0;
         red_q         <= '1;
         grant_pulse_q <= 1'b0;
         busy_q        <= 1'b1;
      end else begin
         state_q       <= state_d;
         active_q      <= active_d;
         green_q       <= green_d;
         yellow_q      <= yellow_d;
         red_q         <= red_d;
         grant_pulse_q <= grant_pulse_d;
         busy_q        <= busy_d;
      end
   end

   assign green       = green_q;
   assign yellow      = yellow_q;
   assign red         = red_q;
   assign grant_pulse = grant_pulse_q;
   assign busy        = busy_q;

endmodule
